// File: rtl/power_spectrum_accumulator_pkg.sv
// Shared state encoding, width helper and saturating shift for the power-spectrum accumulator.
package power_spectrum_accumulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_ACCUM,
        ST_FLUSH,
        ST_DUMP
    } state_e;

    localparam int unsigned SAT_W = 128;

    // Two cycles drain the power pipe and three more settle the RAM, so the
    // first valid_o lands exactly 8 cycles after the last input sample.
    localparam int unsigned FLUSH_CYCLES = 5;

    function automatic int unsigned min_acc_bits(input int unsigned nof_bits,
                                                 input int unsigned log_max_avg);
        return 2 * nof_bits + 1 + log_max_avg;
    endfunction

    function automatic logic [SAT_W-1:0] sat_shr(input logic [SAT_W-1:0] v,
                                                 input logic [3:0]       sh,
                                                 input int unsigned      out_bits);
        logic [SAT_W-1:0] s;
        logic [SAT_W-1:0] lim;
        s   = v >> sh;
        lim = (SAT_W'(1) << out_bits) - SAT_W'(1);
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/power_spectrum_accumulator_if.sv
// Streaming ports: FFT samples in, averaged spectrum out.
interface power_spectrum_accumulator_if #(
    parameter int unsigned NofBits      = 16,
    parameter int unsigned LogNofPoints = 10,
    parameter int unsigned OutBits      = 32
);
    logic signed [NofBits-1:0]      re_i;
    logic signed [NofBits-1:0]      im_i;
    logic        [LogNofPoints-1:0] index_i;
    logic                           valid_i;
    logic        [OutBits-1:0]      data_o;
    logic        [LogNofPoints-1:0] index_o;
    logic                           valid_o;

    modport master (
        output re_i, im_i, index_i, valid_i,
        input  data_o, index_o, valid_o
    );

    modport slave (
        input  re_i, im_i, index_i, valid_i,
        output data_o, index_o, valid_o
    );
endinterface

// File: rtl/power_spectrum_accumulator_spec_bin_ram.sv
// Simple dual-port bin RAM with a registered read port; contents are never reset.
module spec_bin_ram #(
    parameter int unsigned Width    = 48,
    parameter int unsigned AddrBits = 10
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AddrBits-1:0] wr_addr_i,
    input  logic [Width-1:0]    wr_data_i,
    input  logic [AddrBits-1:0] rd_addr_i,
    output logic [Width-1:0]    rd_data_o
);
    logic [Width-1:0] mem_q [2**AddrBits];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wr_addr_i] <= wr_data_i;
        rd_data_o <= mem_q[rd_addr_i];
    end
endmodule

// File: rtl/power_spectrum_accumulator.sv
// Squares streaming FFT bins, sums 2^k frames per bin in RAM, then streams the
// shifted and saturated average out with its own valid strobe.
module power_spectrum_accumulator
    import power_spectrum_accumulator_pkg::*;
#(
    parameter int unsigned NofBits      = 16,
    parameter int unsigned LogNofPoints = 10,
    parameter int unsigned LogMaxAvg    = 8,
    parameter int unsigned AccBits      = 48,
    parameter int unsigned OutBits      = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [3:0]                 avg_log2_i,
    power_spectrum_accumulator_if.slave st,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       drop_o
);
    localparam int unsigned N   = 2 ** LogNofPoints;
    localparam int unsigned SQW = 2 * NofBits;
    localparam int unsigned PW  = 2 * NofBits + 1;
    localparam int unsigned FCW = LogMaxAvg + 1;
    localparam int unsigned FLW = 3;

    if (AccBits < min_acc_bits(NofBits, LogMaxAvg)) begin : g_acc_chk
        $error("AccBits too narrow for NofBits/LogMaxAvg");
    end

    state_e                   state_q, state_d;
    logic [3:0]               k_q, k_d;
    logic [FCW-1:0]           frame_cnt_q, frame_cnt_d;
    logic [FLW-1:0]           flush_cnt_q, flush_cnt_d;
    logic [LogNofPoints-1:0]  dump_addr_q, dump_addr_d;
    logic                     busy_q, busy_d, done_q, done_d, drop_q, drop_d;
    logic                     v1_q, v1_d, first1_q, first1_d, v2_q, v2_d, first2_q, first2_d;
    logic [LogNofPoints-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
    logic signed [SQW-1:0]    sq_re_q, sq_re_d, sq_im_q, sq_im_d;
    logic [PW-1:0]            p_q, p_d;
    logic [AccBits-1:0]       rd_q, rd_d;
    logic                     dv1_q, dv1_d, dlast1_q, dlast1_d, last2_q, last2_d;
    logic [LogNofPoints-1:0]  didx1_q, didx1_d;
    logic                     valid_o_q, valid_o_d;
    logic [LogNofPoints-1:0]  index_o_q, index_o_d;
    logic [OutBits-1:0]       data_o_q, data_o_d;

    logic                     take, dump_rd;
    logic [AccBits-1:0]       ram_rd, p_ext, wr_data;
    logic [LogNofPoints-1:0]  rd_addr;

    assign p_ext   = AccBits'(p_q);
    // The first frame overwrites, so stale RAM from an aborted run never leaks in.
    assign wr_data = first2_q ? p_ext : rd_q + p_ext;
    assign rd_addr = (state_q == ST_DUMP) ? dump_addr_q : st.index_i;

    spec_bin_ram #(.Width(AccBits), .AddrBits(LogNofPoints)) u_ram (
        .clk_i     (clk_i),
        .we_i      (v2_q),
        .wr_addr_i (idx2_q),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rd)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        frame_cnt_d = frame_cnt_q;
        flush_cnt_d = flush_cnt_q;
        dump_addr_d = dump_addr_q;
        busy_d      = busy_q;
        drop_d      = drop_q;
        take        = 1'b0;
        dump_rd     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !busy_q) begin
                    state_d     = ST_WAIT_FRAME;
                    k_d         = (avg_log2_i > 4'(LogMaxAvg)) ? 4'(LogMaxAvg) : avg_log2_i;
                    frame_cnt_d = '0;
                    busy_d      = 1'b1;
                    drop_d      = 1'b0;
                end
            end
            ST_WAIT_FRAME: begin
                if (st.valid_i && st.index_i == '0) begin
                    take    = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (st.valid_i) begin
                    take = 1'b1;
                    if (st.index_i == LogNofPoints'(N - 1)) begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                        flush_cnt_d = FLW'(FLUSH_CYCLES - 1);
                        state_d     = (frame_cnt_d == (FCW'(1) << k_q)) ? ST_FLUSH : ST_WAIT_FRAME;
                    end
                end
            end
            ST_FLUSH: begin
                if (st.valid_i) drop_d = 1'b1;
                if (flush_cnt_q == '0) begin
                    state_d     = ST_DUMP;
                    dump_addr_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLW'(1);
                end
            end
            ST_DUMP: begin
                if (st.valid_i) drop_d = 1'b1;
                dump_rd     = 1'b1;
                dump_addr_d = dump_addr_q + LogNofPoints'(1);
                if (dump_addr_q == LogNofPoints'(N - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        v1_d      = take;
        first1_d  = (frame_cnt_q == '0);
        idx1_d    = st.index_i;
        sq_re_d   = SQW'(st.re_i) * SQW'(st.re_i);
        sq_im_d   = SQW'(st.im_i) * SQW'(st.im_i);
        v2_d      = v1_q;
        first2_d  = first1_q;
        idx2_d    = idx1_q;
        p_d       = {1'b0, sq_re_q} + {1'b0, sq_im_q};
        rd_d      = ram_rd;

        dv1_d     = dump_rd;
        didx1_d   = dump_addr_q;
        dlast1_d  = dump_rd && (dump_addr_q == LogNofPoints'(N - 1));
        last2_d   = dlast1_q;
        valid_o_d = dv1_q;
        index_o_d = dv1_q ? didx1_q : '0;
        data_o_d  = dv1_q ? OutBits'(sat_shr(SAT_W'(ram_rd), k_q, OutBits)) : '0;
        done_d    = last2_q;
        if (last2_q) busy_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            frame_cnt_q <= '0;
            flush_cnt_q <= '0;
            dump_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            idx1_q      <= '0;
            sq_re_q     <= '0;
            sq_im_q     <= '0;
            v2_q        <= 1'b0;
            first2_q    <= 1'b0;
            idx2_q      <= '0;
            p_q         <= '0;
            rd_q        <= '0;
            dv1_q       <= 1'b0;
            didx1_q     <= '0;
            dlast1_q    <= 1'b0;
            last2_q     <= 1'b0;
            valid_o_q   <= 1'b0;
            index_o_q   <= '0;
            data_o_q    <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            frame_cnt_q <= frame_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            dump_addr_q <= dump_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            v1_q        <= v1_d;
            first1_q    <= first1_d;
            idx1_q      <= idx1_d;
            sq_re_q     <= sq_re_d;
            sq_im_q     <= sq_im_d;
            v2_q        <= v2_d;
            first2_q    <= first2_d;
            idx2_q      <= idx2_d;
            p_q         <= p_d;
            rd_q        <= rd_d;
            dv1_q       <= dv1_d;
            didx1_q     <= didx1_d;
            dlast1_q    <= dlast1_d;
            last2_q     <= last2_d;
            valid_o_q   <= valid_o_d;
            index_o_q   <= index_o_d;
            data_o_q    <= data_o_d;
        end
    end

    assign st.data_o  = data_o_q;
    assign st.index_o = index_o_q;
    assign st.valid_o = valid_o_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign drop_o     = drop_q;
endmodule
